// File: rtl/flappy_pkg.sv
// Shared constants for the flappy datapath: screen geometry, one-hot state
// encoding and the gap LFSR seed/taps.
package flappy_pkg;

  localparam int SPAWN_X   = 640;
  localparam int FLOOR_Y   = 460;
  localparam int CEIL_WRAP = 900;
  localparam int GAP_BASE  = 40;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_PLAY = 3'b010;
  localparam logic [2:0] ST_OVER = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_PLAY = ST_PLAY,
    S_OVER = ST_OVER
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic lfsr_fb(input logic [7:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/gap_lfsr.sv
// Free-running 8-bit LFSR producing the next pipe gap top edge (40..295).
module gap_lfsr
  import flappy_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] Gap
);

  logic [7:0] lfsr;

  always_ff @(posedge Clk) begin
    if (Reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], lfsr_fb(lfsr)};
  end

  assign Gap = 10'(GAP_BASE) + {2'b00, lfsr};

endmodule

// File: rtl/pipe_collision.sv
// Pipe scrolling, collision detection and scoring for the flappy round.
// Build option: define SCORE_BCD_EN for a three-digit BCD Score.
module pipe_collision
  import flappy_pkg::*;
#(
  parameter int TICK_DIV  = 500000,
  parameter int SCROLL    = 2,
  parameter int PIPE_W    = 60,
  parameter int GAP_H     = 120,
  parameter int BIRD_SZ   = 16,
  parameter int FLOOR_Y   = flappy_pkg::FLOOR_Y,
  parameter int CEIL_WRAP = flappy_pkg::CEIL_WRAP,
  parameter int SPAWN_X   = flappy_pkg::SPAWN_X
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [9:0]  YBird,
  input  logic [9:0]  XBird,
  output logic [9:0]  PipeX0,
  output logic [9:0]  PipeX1,
  output logic [9:0]  GapY0,
  output logic [9:0]  GapY1,
  output logic [11:0] Score,
  output logic        Lost,
  output logic        q_Idle,
  output logic        q_Play,
  output logic        q_Over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [9:0] SCROLL_V = 10'(SCROLL);
  localparam logic [9:0] X_SPAWN  = 10'(SPAWN_X);
  localparam logic [9:0] X1_INIT  = 10'(SPAWN_X + 320);
  localparam logic [9:0] GAP_RST  = 10'(GAP_BASE) + 10'(LFSR_SEED);

  state_t        state;
  logic [TW-1:0] tick;
  logic [9:0]    x0, x1, gy0, gy1;
  logic [11:0]   score;
  logic          passed0, passed1, lost;
  logic [9:0]    gap;
  logic          step, hit, pass0, pass1, respawn0, respawn1;
  logic [10:0]   bird_bot;

  gap_lfsr u_gap (
    .Clk   (Clk),
    .Reset (Reset),
    .Gap   (gap)
  );

  // All sums are carried in 11 bits so nothing near the 10-bit edge wraps.
  function automatic logic pipe_hit(input logic [9:0] px, input logic [9:0] gy,
                                    input logic [9:0] xb, input logic [9:0] yb);
    logic [10:0] bird_r, bird_b, pipe_r, gap_b;
    bird_r = {1'b0, xb} + 11'(BIRD_SZ);
    bird_b = {1'b0, yb} + 11'(BIRD_SZ);
    pipe_r = {1'b0, px} + 11'(PIPE_W);
    gap_b  = {1'b0, gy} + 11'(GAP_H);
    return (bird_r > {1'b0, px}) && ({1'b0, xb} < pipe_r) &&
           (({1'b0, yb} < {1'b0, gy}) || (bird_b > gap_b));
  endfunction

`ifdef SCORE_BCD_EN
  function automatic logic [11:0] bcd_inc(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    if (s != 12'h999) begin
      if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
      else begin
        r[3:0] = 4'd0;
        if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
        else begin
          r[7:4]  = 4'd0;
          r[11:8] = r[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] score_add(input logic [11:0] s, input logic [1:0] n);
    logic [11:0] r;
    r = s;
    if (n != 2'd0) r = bcd_inc(r);
    if (n == 2'd2) r = bcd_inc(r);
    return r;
  endfunction
`else
  function automatic logic [11:0] score_add(input logic [11:0] s, input logic [1:0] n);
    logic [12:0] t;
    t = {1'b0, s} + 13'(n);
    return (t > 13'd999) ? 12'd999 : t[11:0];
  endfunction
`endif

  assign step     = (tick == TICK_LAST);
  assign bird_bot = {1'b0, YBird} + 11'(BIRD_SZ);
  assign hit      = (bird_bot >= 11'(FLOOR_Y)) || ({1'b0, YBird} >= 11'(CEIL_WRAP)) ||
                    pipe_hit(x0, gy0, XBird, YBird) || pipe_hit(x1, gy1, XBird, YBird);
  assign pass0    = step && !passed0 && (({1'b0, x0} + 11'(PIPE_W)) < {1'b0, XBird});
  assign pass1    = step && !passed1 && (({1'b0, x1} + 11'(PIPE_W)) < {1'b0, XBird});
  assign respawn0 = (x0 < SCROLL_V);
  assign respawn1 = (x1 < SCROLL_V);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      tick    <= '0;
      x0      <= X_SPAWN;
      x1      <= X1_INIT;
      gy0     <= GAP_RST;
      gy1     <= GAP_RST;
      score   <= '0;
      passed0 <= 1'b0;
      passed1 <= 1'b0;
      lost    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          tick    <= '0;
          x0      <= X_SPAWN;
          x1      <= X1_INIT;
          gy0     <= gap;
          gy1     <= gap;
          score   <= '0;
          passed0 <= 1'b0;
          passed1 <= 1'b0;
          if (Start) state <= S_PLAY;
        end
        S_PLAY: begin
          // A hit freezes everything, including any score earned on this step.
          if (hit) begin
            state <= S_OVER;
            lost  <= 1'b1;
          end else begin
            tick <= step ? '0 : tick + TW'(1);
            if (step) begin
              score <= score_add(score, {1'b0, pass0} + {1'b0, pass1});
              if (respawn0) begin
                x0      <= X_SPAWN;
                gy0     <= gap;
                passed0 <= 1'b0;
              end else begin
                x0      <= x0 - SCROLL_V;
                passed0 <= passed0 | pass0;
              end
              if (respawn1) begin
                x1      <= X_SPAWN;
                gy1     <= gap;
                passed1 <= 1'b0;
              end else begin
                x1      <= x1 - SCROLL_V;
                passed1 <= passed1 | pass1;
              end
            end
          end
        end
        S_OVER: begin
          // Leaving OVER restores the idle picture on the same edge.
          if (Start) begin
            state   <= S_IDLE;
            lost    <= 1'b0;
            tick    <= '0;
            x0      <= X_SPAWN;
            x1      <= X1_INIT;
            score   <= '0;
            passed0 <= 1'b0;
            passed1 <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign PipeX0 = x0;
  assign PipeX1 = x1;
  assign GapY0  = gy0;
  assign GapY1  = gy1;
  assign Score  = score;
  assign Lost   = lost;
  assign q_Idle = state[0];
  assign q_Play = state[1];
  assign q_Over = state[2];

endmodule

// File: tb/tb_pipe_collision.sv
// Directed bench for pipe_collision: hit table plus scroll/score/respawn,
// freeze, reset and score-saturation sequences.
module tb_pipe_collision;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [9:0]  xb, yb;
  logic [9:0]  px0, px1, gy0, gy1;
  logic [11:0] score;
  logic        lost, qi, qp, qo;

  logic        rst_b, start_b;
  logic [9:0]  xb_b, yb_b;
  logic [9:0]  px0_b, px1_b, gy0_b, gy1_b;
  logic [11:0] score_b;
  logic        lost_b, qi_b, qp_b, qo_b;

  pipe_collision #(.TICK_DIV(4)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .YBird(yb), .XBird(xb),
    .PipeX0(px0), .PipeX1(px1), .GapY0(gy0), .GapY1(gy1),
    .Score(score), .Lost(lost), .q_Idle(qi), .q_Play(qp), .q_Over(qo)
  );

  pipe_collision #(.TICK_DIV(1), .SCROLL(320)) dut_b (
    .Clk(clk), .Reset(rst_b), .Start(start_b), .YBird(yb_b), .XBird(xb_b),
    .PipeX0(px0_b), .PipeX1(px1_b), .GapY0(gy0_b), .GapY1(gy1_b),
    .Score(score_b), .Lost(lost_b), .q_Idle(qi_b), .q_Play(qp_b), .q_Over(qo_b)
  );

`ifdef SCORE_BCD_EN
  localparam int SC20  = 'h020;
  localparam int SCMAX = 'h999;
`else
  localparam int SC20  = 20;
  localparam int SCMAX = 999;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference LFSR: mg is the gap value the DUT would load on this edge.
  logic [7:0] m;
  logic [9:0] mg;
  always @(posedge clk) begin
    if (rst) begin
      m  <= 8'hA5;
      mg <= 10'd205;
    end else begin
      mg <= 10'd40 + {2'b00, m};
      m  <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end
  end

  typedef struct {
    int x;
    int y;
    bit rel;
    bit lost;
  } vec_t;

  vec_t tv[15];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int k);
    repeat (4 * k) clk1();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk1();
    rst = 1'b0;
  endtask

  task automatic start_play();
    start = 1'b1;
    clk1();
    start = 1'b0;
  endtask

  logic [9:0] g, g0new;

  initial begin
    tv[0]  = '{100,  200, 1'b0, 1'b0};
    tv[1]  = '{100,  443, 1'b0, 1'b0};
    tv[2]  = '{100,  444, 1'b0, 1'b1};
    tv[3]  = '{100, 1000, 1'b0, 1'b1};
    tv[4]  = '{100,  900, 1'b0, 1'b1};
    tv[5]  = '{624,   10, 1'b0, 1'b0};
    tv[6]  = '{625,   10, 1'b0, 1'b1};
    tv[7]  = '{699,   10, 1'b0, 1'b1};
    tv[8]  = '{700,   10, 1'b0, 1'b0};
    tv[9]  = '{944,   10, 1'b0, 1'b0};
    tv[10] = '{945,   10, 1'b0, 1'b1};
    tv[11] = '{625,   10, 1'b1, 1'b0};
    tv[12] = '{625,   -1, 1'b1, 1'b1};
    tv[13] = '{625,  104, 1'b1, 1'b0};
    tv[14] = '{625,  105, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; xb = 10'd100; yb = 10'd200;
    rst_b = 1'b1; start_b = 1'b0; xb_b = 10'd930; yb_b = 10'd100;
    clk1();
    clk1();
    check("rst q_Idle", int'(qi), 1);
    check("rst q_Play", int'(qp), 0);
    check("rst q_Over", int'(qo), 0);
    check("rst Lost", int'(lost), 0);
    check("rst Score", int'(score), 0);
    check("rst PipeX0", int'(px0), 640);
    check("rst PipeX1", int'(px1), 960);
    check("rst GapY0", int'(gy0), 205);
    check("rst GapY1", int'(gy1), 205);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      do_reset();
      start_play();
      g = mg;
      check($sformatf("vec%0d GapY0", i), int'(gy0), int'(g));
      check($sformatf("vec%0d GapY1", i), int'(gy1), int'(g));
      xb = 10'(tv[i].x);
      yb = 10'(tv[i].rel ? int'(g) + tv[i].y : tv[i].y);
      clk1();
      check($sformatf("vec%0d Lost", i), int'(lost), int'(tv[i].lost));
      check($sformatf("vec%0d q_Over", i), int'(qo), int'(tv[i].lost));
    end

    // Long scroll run: bird at X=100 flying through the gaps.
    do_reset();
    xb = 10'd100; yb = 10'd200;
    start_play();
    check("start q_Play", int'(qp), 1);
    g = mg;
    yb = g + 10'd10;
    steps(1);
    check("step1 PipeX0", int'(px0), 638);
    check("step1 PipeX1", int'(px1), 958);
    steps(300);
    check("step301 PipeX0", int'(px0), 38);
    check("step301 Score", int'(score), 0);
    steps(1);
    check("step302 Score", int'(score), 1);
    steps(2);
    check("step304 Score", int'(score), 1);
    steps(15);
    check("step319 PipeX0", int'(px0), 2);
    steps(1);
    check("step320 PipeX0", int'(px0), 0);
    steps(1);
    check("respawn PipeX0", int'(px0), 640);
    check("respawn GapY0", int'(gy0), int'(mg));
    g0new = mg;
    steps(141);
    check("step462 Score", int'(score), 2);
    steps(8);
    yb = g0new + 10'd10;
    steps(153);
    check("step623 Score", int'(score), 3);
    check("step623 PipeX0", int'(px0), 36);
    check("step623 PipeX1", int'(px1), 356);
    check("step623 q_Play", int'(qp), 1);

    // Floor hit, then everything frozen in OVER.
    yb = 10'd465;
    check("pre-hit Lost", int'(lost), 0);
    clk1();
    check("hit Lost", int'(lost), 1);
    check("hit q_Over", int'(qo), 1);
    repeat (50) clk1();
    check("over PipeX0", int'(px0), 36);
    check("over PipeX1", int'(px1), 356);
    check("over GapY0", int'(gy0), int'(g0new));
    check("over Score", int'(score), 3);
    check("over Lost", int'(lost), 1);
    check("over q_Over", int'(qo), 1);

    // Held Start: OVER->IDLE, IDLE->PLAY, then stays in PLAY.
    yb = 10'd200;
    start = 1'b1;
    clk1();
    check("idle q_Idle", int'(qi), 1);
    check("idle Score", int'(score), 0);
    check("idle PipeX0", int'(px0), 640);
    check("idle Lost", int'(lost), 0);
    clk1();
    check("held q_Play", int'(qp), 1);
    repeat (3) clk1();
    check("held stays q_Play", int'(qp), 1);
    start = 1'b0;
    steps(2);
    check("midplay PipeX0", int'(px0), 636);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    check("midrst q_Idle", int'(qi), 1);
    check("midrst PipeX0", int'(px0), 640);
    check("midrst PipeX1", int'(px1), 960);
    check("midrst Score", int'(score), 0);
    check("midrst GapY0", int'(gy0), 205);

    // Fast-scrolling instance drives Score into saturation.
    rst_b = 1'b0;
    clk1();
    start_b = 1'b1;
    clk1();
    start_b = 1'b0;
    repeat (30) clk1();
    check("fast Score30", int'(score_b), SC20);
    repeat (1600) clk1();
    check("sat Score", int'(score_b), SCMAX);
    repeat (50) clk1();
    check("sat hold Score", int'(score_b), SCMAX);
    check("sat Lost", int'(lost_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
